// File: rtl/nibble_seq_adder.sv
// Nibble-serial wide adder controller driving one external 4-bit CLA slice, LSB nibble first.
// Optional signed-overflow output result_ovf is enabled by defining NIBBLE_SEQ_ADDER_OVF_EN.
module nibble_seq_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 op_cin,
    output logic [3:0]           cla_a,
    output logic [3:0]           cla_b,
    output logic                 cla_cin,
    input  logic [3:0]           cla_sum,
    input  logic                 cla_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 result_cout
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
    ,
    output logic                 result_ovf
`endif
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic             carry_reg;
    logic [IDX_W-1:0] nib_idx;
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // The shift registers empty to zero and carry_reg is cleared on the last nibble,
    // so the slice inputs are zero outside RUN without any output gating.
    assign cla_a   = a_sh[3:0];
    assign cla_b   = b_sh[3:0];
    assign cla_cin = carry_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            a_sh        <= '0;
            b_sh        <= '0;
            carry_reg   <= 1'b0;
            nib_idx     <= '0;
            result      <= '0;
            result_cout <= 1'b0;
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            result_ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh      <= op_a;
                        b_sh      <= op_b;
                        carry_reg <= op_cin;
                        nib_idx   <= '0;
                        in_ready  <= 1'b0;
                        state     <= RUN;
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
                        a_msb     <= op_a[W-1];
                        b_msb     <= op_b[W-1];
`endif
                    end
                end
                RUN: begin
                    result[4*nib_idx +: 4] <= cla_sum;
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    nib_idx <= nib_idx + 1'b1;
                    if (nib_idx == LAST_IDX) begin
                        // Top-nibble carry goes only to result_cout, never back into the slice.
                        result_cout <= cla_carry;
                        carry_reg   <= 1'b0;
                        nib_idx     <= '0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
                        result_ovf  <= (a_msb == b_msb) && (cla_sum[3] != a_msb);
`endif
                    end else begin
                        carry_reg <= cla_carry;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
